line_mem_arbiter: RTL

//  - Shares the single 128-bit line-wide data memory between I-cache refill (read-only) and D-cache refill/writeback (read/write).
//  - Sits between both cache controllers and the memory: selects one requester, sequences a one-cycle mem_req, waits for mem_ready, returns data/ack.
//  - Exactly one memory transaction outstanding at any time.

---
 rtl/line_mem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/line_mem_arbiter.sv
// Arbitrates one 128-bit line memory between I-cache refill and D-cache refill/writeback.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed D-cache priority.
module line_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] memory_address,
    output logic [LINE_W-1:0] mem_writedata,
    input  logic [LINE_W-1:0] mem_readdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t            r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic              r_sel_d, w_sel_d_nx;
    logic              r_last_d, w_last_d_nx;
    logic              r_mem_req, w_mem_req_nx;
    logic              r_we, w_we_nx;
    logic [ADDR_W-1:0] r_maddr, w_maddr_nx;
    logic [LINE_W-1:0] r_wdata, w_wdata_nx;
    logic              r_i_ack, w_i_ack_nx;
    logic              r_d_ack, w_d_ack_nx;
    logic [LINE_W-1:0] r_i_rdata, w_i_rdata_nx;
    logic [LINE_W-1:0] r_d_rdata, w_d_rdata_nx;
    logic              r_busy, w_busy_nx;
    logic              r_tmo, w_tmo_nx;

    logic              w_i_elig, w_d_elig, w_pick_d, w_done;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [LINE_W-1:0] w_ret;

    // A requester still holding req during its own ack cycle must not be regranted.
    assign w_i_elig = i_req & ~r_i_ack;
    assign w_d_elig = d_req & ~r_d_ack;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_pick_d = (w_i_elig & w_d_elig) ? ~r_last_d : w_d_elig;
`else
    assign w_pick_d = w_d_elig;
`endif

    assign w_addr_sel = w_pick_d ? d_addr : i_addr;

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_sel_d_nx   = r_sel_d;
        w_last_d_nx  = r_last_d;
        w_mem_req_nx = 1'b0;
        w_we_nx      = r_we;
        w_maddr_nx   = r_maddr;
        w_wdata_nx   = r_wdata;
        w_i_ack_nx   = 1'b0;
        w_d_ack_nx   = 1'b0;
        w_i_rdata_nx = r_i_rdata;
        w_d_rdata_nx = r_d_rdata;
        w_tmo_nx     = r_tmo;
        w_done       = 1'b0;
        w_ret        = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_i_elig | w_d_elig) begin
                    w_sel_d_nx   = w_pick_d;
                    w_last_d_nx  = w_pick_d;
                    w_mem_req_nx = 1'b1;
                    w_maddr_nx   = {w_addr_sel[ADDR_W-1:4], 4'b0000};
                    w_we_nx      = w_pick_d & d_we;
                    w_wdata_nx   = w_pick_d ? d_wdata : '0;
                    w_cnt_nx     = '0;
                    w_state_nx   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    w_ret  = mem_readdata;
                    w_done = 1'b1;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_tmo_nx = 1'b1;
                    w_done   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
                if (w_done) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                    if (r_sel_d) begin
                        w_d_ack_nx   = 1'b1;
                        w_d_rdata_nx = w_ret;
                    end else begin
                        w_i_ack_nx   = 1'b1;
                        w_i_rdata_nx = w_ret;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sel_d   <= 1'b0;
            r_last_d  <= 1'b0;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
            r_maddr   <= '0;
            r_wdata   <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_busy    <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_sel_d   <= w_sel_d_nx;
            r_last_d  <= w_last_d_nx;
            r_mem_req <= w_mem_req_nx;
            r_we      <= w_we_nx;
            r_maddr   <= w_maddr_nx;
            r_wdata   <= w_wdata_nx;
            r_i_ack   <= w_i_ack_nx;
            r_d_ack   <= w_d_ack_nx;
            r_i_rdata <= w_i_rdata_nx;
            r_d_rdata <= w_d_rdata_nx;
            r_busy    <= w_busy_nx;
            r_tmo     <= w_tmo_nx;
        end
    end

    assign i_rdata        = r_i_rdata;
    assign i_ack          = r_i_ack;
    assign d_rdata        = r_d_rdata;
    assign d_ack          = r_d_ack;
    assign mem_req        = r_mem_req;
    assign WriteEnable    = r_we;
    assign memory_address = r_maddr;
    assign mem_writedata  = r_wdata;
    assign busy           = r_busy;
    assign timeout_err    = r_tmo;

endmodule
